// File: rtl/program_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words and writes them
// to instruction memory, holding the CPU in reset until done. Optional macro: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'd0,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        initialize,
  output logic [31:0] instruction_initialize_data,
  output logic [31:0] instruction_initialize_address,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ASM, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  hdr_hi_q, hdr_hi_d;
  logic [23:0] shift_q, shift_d;
  logic [15:0] n_words_q, n_words_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [31:0] data_q, data_d;
  logic [31:0] addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
  localparam state_t S_AFTER_PAYLOAD = S_CHK;
`else
  localparam state_t S_AFTER_PAYLOAD = S_DONE;
`endif

  logic        accept;
  logic [15:0] hdr_word;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    hdr_hi_d   = hdr_hi_q;
    shift_d    = shift_q;
    n_words_d  = n_words_q;
    word_idx_d = word_idx_q;
    data_d     = data_q;
    addr_d     = addr_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    byte_ready = (state_q == S_HDR) || (state_q == S_ASM) || (state_q == S_CHK);
    initialize = (state_q == S_WRITE);
    busy       = byte_ready || initialize;
    done       = (state_q == S_DONE);
    error      = (state_q == S_ERR);
    cpu_rst    = (state_q != S_DONE);
    accept     = byte_valid && byte_ready;
    hdr_word   = {hdr_hi_q, byte_data};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
        end
      end
      S_HDR: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            hdr_hi_d   = byte_data;
            byte_cnt_d = 2'd1;
          end else begin
            byte_cnt_d = 2'd0;
            n_words_d  = hdr_word;
            word_idx_d = 16'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = 8'd0;
`endif
            if (hdr_word == 16'd0)
              state_d = S_AFTER_PAYLOAD;
            else if ({16'd0, hdr_word} > 32'(DEPTH_WORDS))
              state_d = S_ERR;
            else
              state_d = S_ASM;
          end
        end
      end
      S_ASM: begin
        if (accept) begin
          shift_d    = {shift_q[15:0], byte_data};
          byte_cnt_d = 2'(byte_cnt_q + 2'd1);
`ifdef LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ byte_data;
`endif
          // Latch data and address on the 4th byte so both are stable through WRITE.
          if (byte_cnt_q == 2'd3) begin
            data_d  = {shift_q, byte_data};
            addr_d  = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == n_words_q)
          state_d = S_AFTER_PAYLOAD;
        else
          state_d = S_ASM;
      end
      S_CHK: begin
`ifdef LOADER_CHECKSUM_EN
        if (accept)
          state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= 2'd0;
      hdr_hi_q   <= 8'd0;
      shift_q    <= 24'd0;
      n_words_q  <= 16'd0;
      word_idx_q <= 16'd0;
      data_q     <= 32'd0;
      addr_q     <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_hi_q   <= hdr_hi_d;
      shift_q    <= shift_d;
      n_words_q  <= n_words_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign instruction_initialize_data    = data_q;
  assign instruction_initialize_address = addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader; records every initialize pulse and compares
// against hand-written word tables. Honours LOADER_CHECKSUM_EN when defined.
module tb_program_loader;
  localparam logic [31:0] BASE = 32'h100;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, initialize, cpu_rst, busy, done, error;
  logic [31:0] init_data, init_addr;

  program_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(64)) u_dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .byte_valid                     (byte_valid),
    .byte_data                      (byte_data),
    .byte_ready                     (byte_ready),
    .initialize                     (initialize),
    .instruction_initialize_data    (init_data),
    .instruction_initialize_address (init_addr),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done),
    .error                          (error)
  );

  always #5 clk = ~clk;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          ready_in_write = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] prog[0:7];
  logic [7:0]  csum_acc;

  always @(negedge clk) begin
    if (rst && initialize) begin
      wr_addr.push_back(init_addr);
      wr_data.push_back(init_data);
      if (byte_ready) ready_in_write++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    csum_acc = 8'h00;
  endtask

  // Present a byte and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    repeat (gap) tick();
    byte_data  = b;
    byte_valid = 1'b1;
    waited = 0;
    while (!byte_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
    else tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int j = 3; j >= 0; j--) begin
      csum_acc ^= w[8*j +: 8];
      send_byte(w[8*j +: 8], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    end
  endtask

  task automatic send_header(input int n);
    logic [15:0] h;
    h = 16'(n);
    send_byte(h[15:8], 0);
    send_byte(h[7:0], 0);
  endtask

  task automatic load(input int n, input int maxgap);
    send_header(n);
    for (int k = 0; k < n; k++) send_word(prog[k], maxgap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(csum_acc, 0);
`endif
  endtask

  task automatic wait_status();
    int i;
    i = 0;
    while (!done && !error && i < 20) begin
      tick();
      i++;
    end
  endtask

  task automatic verify(input string tag, input int n);
    check_eq({tag, "_count"}, 32'(wr_addr.size()), 32'(n));
    for (int k = 0; k < n && k < wr_addr.size(); k++) begin
      check_eq($sformatf("%s_addr%0d", tag, k), wr_addr[k], BASE + 32'(4 * k));
      check_eq($sformatf("%s_data%0d", tag, k), wr_data[k], prog[k]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check_eq({tag, "_init"},  32'(initialize), 32'd0);
    check_eq({tag, "_busy"},  32'(busy), 32'd0);
    check_eq({tag, "_done"},  32'(done), 32'd0);
    check_eq({tag, "_error"}, 32'(error), 32'd0);
    check_eq({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
    check_eq({tag, "_data"},  init_data, 32'd0);
    check_eq({tag, "_addr"},  init_addr, 32'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    csum_acc = 8'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Two-word program with timing checks around the first WRITE
    prog[0] = 32'h20010005; prog[1] = 32'h8C020004;
    clear_log();
    do_start();
    check_eq("hdr_busy", 32'(busy), 32'd1);
    check_eq("hdr_ready", 32'(byte_ready), 32'd1);
    send_header(2);
    send_word(prog[0], 0);
    check_eq("w0_init", 32'(initialize), 32'd1);
    check_eq("w0_ready_low", 32'(byte_ready), 32'd0);
    check_eq("w0_addr", init_addr, BASE);
    check_eq("w0_data", init_data, 32'h20010005);
    tick();
    check_eq("w0_init_end", 32'(initialize), 32'd0);
    check_eq("w0_ready_back", 32'(byte_ready), 32'd1);
    send_word(prog[1], 0);
`ifdef LOADER_CHECKSUM_EN
    tick();
    send_byte(csum_acc, 0);
`else
    tick();
`endif
    check_eq("two_done", 32'(done), 32'd1);
    check_eq("two_cpurst", 32'(cpu_rst), 32'd0);
    check_eq("two_busy", 32'(busy), 32'd0);
    verify("two", 2);
    $display("[TB] load 2 words: %0d writes, done=%0b", wr_addr.size(), done);

    // Empty program
    clear_log();
    do_start();
    send_header(0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    check_eq("empty_done", 32'(done), 32'd1);
    tick();
    check_eq("empty_count", 32'(wr_addr.size()), 32'd0);
    $display("[TB] load 0 words: done=%0b", done);

    // Oversize header, then recovery
    clear_log();
    do_start();
    send_header(65);
    check_eq("big_error", 32'(error), 32'd1);
    check_eq("big_ready", 32'(byte_ready), 32'd0);
    check_eq("big_cpurst", 32'(cpu_rst), 32'd1);
    check_eq("big_done", 32'(done), 32'd0);
    repeat (3) tick();
    check_eq("big_count", 32'(wr_addr.size()), 32'd0);
    $display("[TB] oversize header 0041: error=%0b", error);
    prog[0] = 32'h12345678;
    clear_log();
    do_start();
    load(1, 0);
    wait_status();
    check_eq("recover_done", 32'(done), 32'd1);
    verify("recover", 1);
    $display("[TB] recovery load 1 word: done=%0b", done);

    // Eight words with random source gaps
    prog[0] = 32'h00000001; prog[1] = 32'hDEADBEEF; prog[2] = 32'h01234567; prog[3] = 32'h89ABCDEF;
    prog[4] = 32'hFFFFFFFF; prog[5] = 32'h00000000; prog[6] = 32'hA5A55A5A; prog[7] = 32'h0F0F00F0;
    clear_log();
    ready_in_write = 0;
    do_start();
    load(8, 3);
    wait_status();
    check_eq("gap_done", 32'(done), 32'd1);
    verify("gap", 8);
    check_eq("gap_ready_in_write", 32'(ready_in_write), 32'd0);
    $display("[TB] load 8 words with gaps: %0d writes", wr_addr.size());

    // Reset in the middle of word 1
    prog[0] = 32'hAABBCCDD; prog[1] = 32'h11223344;
    clear_log();
    do_start();
    send_header(2);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b1;
    tick();
    check_eq("midrst_count", 32'(wr_addr.size()), 32'd0);
    clear_log();
    do_start();
    load(2, 0);
    wait_status();
    check_eq("reload_done", 32'(done), 32'd1);
    verify("reload", 2);
    $display("[TB] reset mid-word then reload: %0d writes", wr_addr.size());

`ifdef LOADER_CHECKSUM_EN
    // Corrupted checksum byte
    prog[0] = 32'h20010005; prog[1] = 32'h8C020004;
    clear_log();
    do_start();
    send_header(2);
    send_word(prog[0], 0);
    send_word(prog[1], 0);
    send_byte(csum_acc ^ 8'hFF, 0);
    wait_status();
    check_eq("badchk_error", 32'(error), 32'd1);
    check_eq("badchk_done", 32'(done), 32'd0);
    check_eq("badchk_cpurst", 32'(cpu_rst), 32'd1);
    verify("badchk", 2);
    $display("[TB] bad checksum: error=%0b", error);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
